// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding uart_tx one word per frame.
// Optional feature: define UART_TX_FIFO_TIMEOUT_EN to reissue a word when the
// transmitter never leaves idle within TIMEOUT_CYCLES cycles of the valid pulse.
module uart_tx_fifo #(
  parameter int unsigned UART_DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                       i_clk_sys,
  input  logic                       i_rst,
  input  logic [UART_DATA_WIDTH-1:0] i_wr_data,
  input  logic                       i_wr_en,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [FIFO_DEPTH_LOG2:0]   o_level,
  output logic                       o_overflow,
  input  logic                       i_uart_idle,
  output logic [UART_DATA_WIDTH-1:0] o_data_tx,
  output logic                       o_data_valid,
  output logic                       o_busy
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                     state;
  logic [UART_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [LVL_W-1:0]           level_next;
  logic                       wr_accept;
  logic                       pop;

`ifdef UART_TX_FIFO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // A full FIFO rejects writes even when a pop happens on the same edge.
  assign wr_accept = i_wr_en && !o_full;
  assign pop       = (state == IDLE) && !o_empty && i_uart_idle;

  // Next occupancy from the write/pop pair.
  always_comb begin
    level_next = o_level;
    case ({wr_accept, pop})
      2'b10:   level_next = o_level + LVL_W'(1);
      2'b01:   level_next = o_level - LVL_W'(1);
      default: level_next = o_level;
    endcase
  end

  // Storage array; contents need no reset since the level gates every read.
  always_ff @(posedge i_clk_sys) begin
    if (wr_accept) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, level, registered full/empty flags and overflow pulse.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      o_level    <= level_next;
      o_full     <= (level_next == LVL_W'(DEPTH));
      o_empty    <= (level_next == '0);
      o_overflow <= i_wr_en && o_full;
    end
  end

  // Dispatcher: issue one word, wait for the transmitter to go busy, then idle.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state        <= IDLE;
      o_data_tx    <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
`ifdef UART_TX_FIFO_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_data_tx    <= mem[rd_ptr];
            o_data_valid <= 1'b1;
            o_busy       <= 1'b1;
            state        <= WAIT_BUSY;
`ifdef UART_TX_FIFO_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        WAIT_BUSY: begin
          if (!i_uart_idle) begin
            state <= WAIT_DONE;
          end
`ifdef UART_TX_FIFO_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Transmitter missed the pulse: resend the held word, no extra pop.
            o_data_valid <= 1'b1;
            tmo_cnt      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        WAIT_DONE: begin
          if (i_uart_idle) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
